// File: rtl/serial_tx_pkg.sv
// ----------------------------------------------------------------------------
// serial_tx_pkg
//   Shared definitions for the serial frame transmitter:
//   - tx_state_e : 3-bit FSM state encoding (ST_IDLE .. ST_STOP)
//   - LINE_IDLE / LINE_START : serial line levels
//   - cnt_width() : counter width helper, max(1, clog2(n))
//   Optional feature macro used by the design: SERIAL_TX_PARITY_EN
// ----------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // max(1, clog2(n)); a counter over 0..n-1 always needs at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// ----------------------------------------------------------------------------
// bit_timer
//   Counts clock cycles within one serial bit period.
//   Parameters : CLKS_PER_BIT - cycles per line bit (>= 1)
//   Ports      : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                clear - hold the count at 0 (used while the line is idle)
//                tick  - high in the last cycle of each bit period
//   Macro      : none (SERIAL_TX_PARITY_EN affects only the top level)
// ----------------------------------------------------------------------------
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wraps to 0 on every bit boundary, so each bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// ----------------------------------------------------------------------------
// serial_tx
//   Parallel-in, serial-out frame transmitter. Sends start bit (0), N data
//   bits LSB first, an optional even-parity bit, and a stop bit (1). Each
//   line bit is held CLKS_PER_BIT cycles.
//   Parameters : N            - data word width (>= 1)
//                CLKS_PER_BIT - cycles per line bit (>= 1)
//   Ports      : clk          - clock, rising edge
//                rst_n        - synchronous active-low reset
//                data_in      - word to send, sampled only on accept
//                in_valid     - producer offers a word
//                in_ready     - transmitter can accept (IDLE only)
//                outstream    - serial line, idles high
//                busy         - frame in progress
//                done         - pulse in the final cycle of the stop bit
//                dbg_state_o  - current FSM state (tx_state_e encoding)
//   Macro      : SERIAL_TX_PARITY_EN - adds the PARITY state/bit
//
//   Handshake: a word is accepted at a rising edge where in_valid and
//   in_ready are both high. in_ready depends only on registered state, so
//   in_valid may be held high; it is ignored while busy.
// ----------------------------------------------------------------------------
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         outstream,
  output logic         busy,
  output logic         done,
  output logic [2:0]   dbg_state_o
);

  localparam int unsigned   BW       = cnt_width(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  tx_state_e     state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic          tick;
  logic          accept;
`ifdef SERIAL_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // Timer is held at 0 while idle so the start bit gets a full period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  assign accept = in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_idx_d = bit_idx_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_d      = data_in;
          bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^data_in;
`endif
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          sh_d = sh_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_idx_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_idx_q <= bit_idx_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    outstream = LINE_IDLE;
    case (state_q)
      ST_START:  outstream = LINE_START;
      ST_DATA:   outstream = sh_q[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: outstream = parity_q;
`endif
      default:   outstream = LINE_IDLE;
    endcase
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_STOP) && tick;
  assign dbg_state_o = state_q;

endmodule
